instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 86 ++++++++
 tb/tb_instr_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction loader: takes a length word and then that many instruction words
// from the host, writes them to instruction memory and keeps a running checksum.
module instr_loader #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] count,
  output logic        instr_enable,
  output logic [31:0] chksum,
  output logic        err
);

  typedef enum logic [1:0] {
    WAIT_LEN,
    LOAD,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] idx;
  logic        xfer;
  logic        len_ok;
  logic        last_word;

  always_comb begin
    state_next   = state;
    in_ready     = (state != DONE);
    instr_enable = (state == DONE);
    xfer         = in_valid && in_ready;
    len_ok       = (in_data != '0) && (in_data <= DEPTH);
    last_word    = (idx == count - 32'd1);
    unique case (state)
      WAIT_LEN: if (xfer && len_ok)    state_next = LOAD;
      LOAD:     if (xfer && last_word) state_next = DONE;
      DONE:     if (reload)            state_next = WAIT_LEN;
      default:                         state_next = WAIT_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LEN;
    else     state <= state_next;
  end

  // count and chksum survive a reload; they are only cleared by reset or a new length
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      chksum    <= '0;
      idx       <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      if (state == WAIT_LEN && xfer) begin
        if (len_ok) begin
          count  <= in_data;
          idx    <= '0;
          chksum <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == LOAD && xfer) begin
        mem_we    <= 1'b1;
        mem_addr  <= idx;
        mem_wdata <= in_data;
        idx       <= idx + 32'd1;
        chksum    <= chksum + in_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus random programs,
// compared every cycle against a word-counting reference model.
module tb_instr_loader;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] count;
  logic        instr_enable;
  logic [31:0] chksum;
  logic        err;

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .count        (count),
    .instr_enable (instr_enable),
    .chksum       (chksum),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks "expecting a length" and "words still to come"
  bit          started = 0;
  bit          m_enable = 0;
  bit          m_need_len = 1;
  bit          m_we = 0;
  bit          m_err = 0;
  logic [31:0] m_count = '0, m_sum = '0, m_addr = '0, m_wdata = '0;
  logic [31:0] m_next = '0, m_remaining = '0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1; m_enable = 0; m_need_len = 1; m_we = 0; m_err = 0;
      m_count = '0; m_sum = '0; m_addr = '0; m_wdata = '0; m_next = '0; m_remaining = '0;
    end else begin
      m_we  = 0;
      m_err = 0;
      if (m_enable) begin
        if (reload) begin
          m_enable   = 0;
          m_need_len = 1;
        end
      end else if (in_valid) begin
        if (m_need_len) begin
          if (in_data >= 32'd1 && in_data <= DEPTH) begin
            m_count = in_data; m_remaining = in_data; m_next = '0; m_sum = '0; m_need_len = 0;
          end else begin
            m_err = 1;
          end
        end else begin
          m_we = 1; m_addr = m_next; m_wdata = in_data;
          m_next = m_next + 32'd1;
          m_sum = m_sum + in_data;
          m_remaining = m_remaining - 32'd1;
          if (m_remaining == 0) m_enable = 1;
        end
      end
    end
  end

  int          cyc = 0;
  int          err_seen = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(!m_enable));
      check("instr_enable", 32'(instr_enable), 32'(m_enable));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("count", count, m_count);
      check("chksum", chksum, m_sum);
      check("err", 32'(err), 32'(m_err));
      if (mem_we === 1'b1) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
        log_cyc.push_back(cyc);
      end
      if (err === 1'b1) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] w);
    logic ok;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 50; n++) begin
      ok = in_ready;
      tick();
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = $urandom;
    repeat (n) tick();
  endtask

  task automatic do_reload();
    in_valid = 1'b0;
    reload   = 1'b1;
    tick();
    reload   = 1'b0;
  endtask

  int n0;
  int e0;
  int len;

  initial begin
    rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    check("count_after_rst", count, 32'd0);

    // basic back-to-back load
    send(32'd3); send(32'hA); send(32'hB); send(32'hC);
    idle(2);
    check("basic_nwrites", 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("basic_addr", log_addr[i], 32'(i));
      check("basic_data", log_data[i], 32'hA + 32'(i));
    end
    check("basic_consecutive", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    check("basic_count", count, 32'd3);
    check("basic_chksum", chksum, 32'h21);
    check("basic_enable", 32'(instr_enable), 32'd1);
    check("basic_ready", 32'(in_ready), 32'd0);

    // reload with in_valid high in DONE: no transfer, enable drops
    in_valid = 1'b1; in_data = 32'd7; reload = 1'b1;
    tick();
    reload = 1'b0; in_valid = 1'b0;
    check("reload_enable", 32'(instr_enable), 32'd0);
    check("reload_count_kept", count, 32'd3);
    check("reload_ready", 32'(in_ready), 32'd1);
    send(32'd2);
    reload = 1'b1;
    send(32'h11);
    reload = 1'b0;
    send(32'h22);
    idle(1);
    check("reload_load_chksum", chksum, 32'h33);
    check("reload_load_enable", 32'(instr_enable), 32'd1);

    // rejected lengths
    do_reload();
    e0 = err_seen; n0 = log_addr.size();
    send(32'd0); send(DEPTH + 1);
    idle(2);
    check("reject_err_pulses", 32'(err_seen - e0), 32'd2);
    check("reject_no_write", 32'(log_addr.size() - n0), 32'd0);
    check("reject_ready", 32'(in_ready), 32'd1);
    send(32'd1); send(32'hFFFF_FFFF);
    idle(1);
    check("single_addr", log_addr[$], 32'd0);
    check("single_data", log_data[$], 32'hFFFF_FFFF);
    check("single_enable", 32'(instr_enable), 32'd1);

    // checksum wrap
    do_reload();
    send(32'd2); send(32'hFFFF_FFFF); send(32'd2);
    idle(1);
    check("wrap_chksum", chksum, 32'd1);

    // stalls between payload words
    do_reload();
    n0 = log_addr.size();
    send(32'd4);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send($urandom);
    end
    idle(1);
    check("stall_nwrites", 32'(log_addr.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) check("stall_addr", log_addr[n0 + i], 32'(i));

    // reset in the middle of a load
    do_reload();
    send(32'd5); send($urandom); send($urandom);
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_count", count, 32'd0);
    check("midrst_chksum", chksum, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    send(32'd2); send(32'h5); send(32'h6);
    idle(1);
    check("midrst_reload_count", count, 32'd2);
    check("midrst_reload_chksum", chksum, 32'hB);

    // random programs
    for (int p = 0; p < 40; p++) begin
      do_reload();
      if ($urandom_range(0, 3) == 0) send(($urandom_range(0, 1) == 0) ? 32'd0 : DEPTH + $urandom_range(1, 1000));
      len = $urandom_range(1, DEPTH);
      send(32'(len));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        reload = ($urandom_range(0, 4) == 0);
        send($urandom);
        reload = 1'b0;
      end
      idle($urandom_range(0, 2));
      check("rand_count", count, 32'(len));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
